apb_completer_mem: RTL and testbench
====================================

# apb_completer_mem

APB3 completer (slave) holding a word-addressed register memory with a parameterised number of wait states and PSLVERR error reporting. It is the responding end of the APB bus carried by the team's APB interface: it receives PSELx/PENABLE/PADDR/PWRITE/PWDATA and returns PRDATA/PREADY/PSLVERR. It serves as the reference slave behind the APB master in the UVM environment and as a standalone DUT for completer-side tests.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 32.
- ADDR_WIDTH, 32, width of PADDR (byte address).
- MEM_DEPTH, 16, number of DATA_WIDTH words; power of two, 2..256.
- WAIT_CYCLES, 0, wait states inserted per transfer; 0..15.
- PCLK input 1 — single clock; all logic on the rising edge.
- PRESET input 1 — synchronous, active-high reset.
- PSEL input 1 — completer select (one bit of the bus PSELx).
- PENABLE input 1 — access-phase indicator.
- PADDR input ADDR_WIDTH — byte address.
- PWRITE input 1 — 1 = write, 0 = read.
- PWDATA input DATA_WIDTH — write data.
- PRDATA output DATA_WIDTH — read data; valid only when PREADY=1 on a read.
- PREADY output 1 — transfer completes in a cycle where PSEL&PENABLE&PREADY.
- PSLVERR output 1 — error flag; meaningful only when PREADY=1.

## Operation
- All outputs are registered. Reset values: PRDATA=0, PREADY=0, PSLVERR=0. Reset also clears every memory word to 0, sets state to IDLE and sets the wait counter to 0.
- Word index is PADDR[log2(MEM_DEPTH)+1:2].
- A transfer is an error if PADDR[1:0]!=0, or if any PADDR bit at or above log2(MEM_DEPTH)+2 is set (out of range).
- FSM states:
  - IDLE: on a rising edge with PSEL=1 and PENABLE=0 (setup phase), capture PADDR, PWRITE and PWDATA, and compute the error flag.
    - If WAIT_CYCLES=0: go to ACCESS with PREADY<=1, PSLVERR<=err, and PRDATA<=(read & !err) ? mem[idx] : 0.
    - Otherwise: go to ACCESS with PREADY<=0 and cnt<=WAIT_CYCLES-1... counting so that PREADY is first high in the (WAIT_CYCLES+1)-th access cycle.
    - Any other input combination: stay in IDLE.
  - ACCESS, PREADY=0: if PSEL=1 and PENABLE=1 and cnt!=0, cnt<=cnt-1. When cnt==0, load PREADY<=1 together with PSLVERR and PRDATA as above. PRDATA is sampled from memory at this edge.
  - ACCESS, PREADY=1, PSEL&PENABLE: completion edge.
    - Write without error: mem[idx]<=captured PWDATA.
    - Errored write: memory unchanged.
    - Always: PREADY<=0, PSLVERR<=0, PRDATA<=0, go to IDLE.
- Protocol abort: in ACCESS, if PSEL=0 or PENABLE=0 at any edge, go to IDLE and clear all outputs. No memory write occurs.
- Back-to-back transfers: the master must present a new setup cycle after completion. IDLE accepts it on the very next edge, so there are no dead cycles beyond the APB minimum.
- Address, direction and write data are taken from the setup-phase capture. Changes to PADDR/PWDATA during the access phase are ignored.

## Timing
- Transfer length is 2+WAIT_CYCLES cycles: 1 setup cycle plus WAIT_CYCLES+1 access cycles.
- PREADY is high for exactly one cycle per transfer.
- PRDATA and PSLVERR are nonzero only in the PREADY=1 cycle.
- Write data becomes visible to a subsequent read that starts in the cycle after completion.
- PRESET asserted in any cycle, including mid-access with PREADY=1, takes priority over everything. Outputs are 0 in the following cycle and any pending write is dropped.

## Test plan
- Reset, then read address 0x0 with WAIT_CYCLES=0 → PREADY high in cycle 2, PRDATA=0x0, PSLVERR=0.
- Write 0xDEADBEEF to 0x3C, then read 0x3C (MEM_DEPTH=16) → read returns 0xDEADBEEF with PSLVERR=0. Repeat with WAIT_CYCLES=3 → PREADY low for exactly 3 access cycles, then high for 1.
- Write 0x12345678 to 0x40 (out of range) and to 0x06 (misaligned) → PSLVERR=1 with PREADY. Subsequent reads of words 0 and 1 return their previous values; the read of 0x40 gives PRDATA=0, PSLVERR=1.
- Back-to-back writes to 0x0, 0x4 and 0x8 with data 1, 2, 3, followed by reads → data 1, 2, 3 returned. Each transfer is exactly 2+WAIT_CYCLES cycles with no idle gaps.
- Drop PSEL during the access phase of a write to 0x10 (WAIT_CYCLES=2) → PREADY never asserts for it, FSM returns to IDLE, and a read of 0x10 returns the old value.
- Assert PRESET for one cycle during the PREADY=1 cycle of a write of 0xA5A5A5A5 to 0x8 → outputs 0 in the next cycle, and a read of 0x8 returns 0.

Source files
------------

// File: rtl/apb_completer_mem.sv
// APB3 completer with a word-addressed register memory, programmable wait states and PSLVERR.
// Latency 2+WAIT_CYCLES cycles per transfer; stalls via PREADY, and an access phase dropped by the master aborts the transfer.
module apb_completer_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  ready_d, slverr_d;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IW-1:0]         setup_idx;
  logic                  setup_err;

  // Misaligned, or any address bit beyond the memory window set.
  assign setup_idx = PADDR[IW+1:2];
  assign setup_err = (PADDR[1:0] != 2'b00) || ((PADDR >> (IW + 2)) != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = PRDATA;
    ready_d  = PREADY;
    slverr_d = PSLVERR;
    mem_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          idx_d   = setup_idx;
          err_d   = setup_err;
          write_d = PWRITE;
          wdata_d = PWDATA;
          if (WAIT_CYCLES == 0) begin
            ready_d  = 1'b1;
            slverr_d = setup_err;
            rdata_d  = (!PWRITE && !setup_err) ? mem[setup_idx] : '0;
          end else begin
            ready_d  = 1'b0;
            slverr_d = 1'b0;
            rdata_d  = '0;
            cnt_d    = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
          rdata_d  = '0;
        end else if (PREADY) begin
          mem_we   = write_q && !err_q;
          state_d  = IDLE;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
          rdata_d  = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d  = 1'b1;
          slverr_d = err_q;
          rdata_d  = (!write_q && !err_q) ? mem[idx_q] : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      PRDATA  <= rdata_d;
      PREADY  <= ready_d;
      PSLVERR <= slverr_d;
      if (mem_we) mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Bench for apb_completer_mem: three instances with 0, 2 and 3 wait states against a word-array reference model.
module tb_apb_completer_mem;

  localparam int WS [3] = '{0, 2, 3};

  logic        clk;
  logic        rst;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic [31:0] mdl [3][16];
  logic [31:0] last_rd;
  logic        last_err;
  int          checks;
  int          errors;

  apb_completer_mem #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_completer_mem #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_completer_mem #(.WAIT_CYCLES(3)) u_w3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable[2]), .PADDR(paddr[2]),
    .PWRITE(pwrite[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) mdl[k][i] = 32'h0;
  endtask

  task automatic outputs_zero(input int k, input string tag);
    chk({tag, "_rdy"}, 32'(pready[k]), 32'h0);
    chk({tag, "_rd"}, prdata[k], 32'h0);
    chk({tag, "_err"}, 32'(pslverr[k]), 32'h0);
  endtask

  // One full transfer; leaves the bus ready for a back-to-back setup in the same cycle.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    bit          done;
    exp_err = (addr % 4 != 0) || (addr >= 64);
    exp_rd  = (!wr && !exp_err) ? mdl[k][addr / 4] : 32'h0;
    psel[k] = 1'b1; penable[k] = 1'b0; paddr[k] = addr; pwrite[k] = wr; pwdata[k] = data;
    @(posedge clk); #1;
    penable[k] = 1'b1; paddr[k] = $urandom; pwdata[k] = $urandom;
    n = 1; done = 0;
    while (!done && n <= 20) begin
      if (pready[k]) done = 1;
      else begin @(posedge clk); #1; n++; end
    end
    chk("ready_seen", 32'(done), 32'h1);
    if (done) begin
      chk("access_cycles", 32'(n), 32'(WS[k] + 1));
      chk("rdata", prdata[k], exp_rd);
      chk("slverr", 32'(pslverr[k]), 32'(exp_err));
      last_rd = prdata[k]; last_err = pslverr[k];
      @(posedge clk); #1;
      outputs_zero(k, "post");
      if (wr && !exp_err) mdl[k][addr / 4] = data;
    end
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = 0; pwdata[k] = 0;
    end
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) outputs_zero(k, "reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // First read after reset, zero wait states.
    xfer(0, 1'b0, 32'h0, 32'h0);
    chk("rd0_init", last_rd, 32'h0);

    for (int k = 0; k < 3; k += 2) begin
      xfer(k, 1'b1, 32'h3C, 32'hDEADBEEF);
      xfer(k, 1'b0, 32'h3C, 32'h0);
      chk("deadbeef", last_rd, 32'hDEADBEEF);
      chk("deadbeef_err", 32'(last_err), 32'h0);
      xfer(k, 1'b1, 32'h0, 32'h11);
      xfer(k, 1'b1, 32'h4, 32'h22);
      xfer(k, 1'b1, 32'h40, 32'h12345678);
      chk("oor_wr_err", 32'(last_err), 32'h1);
      xfer(k, 1'b1, 32'h06, 32'h12345678);
      chk("mis_wr_err", 32'(last_err), 32'h1);
      xfer(k, 1'b0, 32'h0, 32'h0);
      chk("w0_kept", last_rd, 32'h11);
      xfer(k, 1'b0, 32'h4, 32'h0);
      chk("w1_kept", last_rd, 32'h22);
      xfer(k, 1'b0, 32'h40, 32'h0);
      chk("oor_rd_data", last_rd, 32'h0);
      chk("oor_rd_err", 32'(last_err), 32'h1);
      // Back-to-back: no idle cycles between transfers.
      xfer(k, 1'b1, 32'h0, 32'h1);
      xfer(k, 1'b1, 32'h4, 32'h2);
      xfer(k, 1'b1, 32'h8, 32'h3);
      for (int i = 0; i < 3; i++) begin
        xfer(k, 1'b0, 32'(4 * i), 32'h0);
        chk("b2b_rd", last_rd, 32'(i + 1));
      end
    end

    // Abort: master drops PSEL mid-access on the two-wait-state instance.
    xfer(1, 1'b1, 32'h10, 32'h0BADF00D);
    psel[1] = 1; penable[1] = 0; paddr[1] = 32'h10; pwrite[1] = 1; pwdata[1] = 32'hFFFF0000;
    @(posedge clk); #1;
    penable[1] = 1;
    chk("abort_a1", 32'(pready[1]), 32'h0);
    @(posedge clk); #1;
    chk("abort_a2", 32'(pready[1]), 32'h0);
    psel[1] = 0; penable[1] = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      outputs_zero(1, "abort_idle");
    end
    xfer(1, 1'b0, 32'h10, 32'h0);
    chk("abort_old", last_rd, 32'h0BADF00D);

    // Reset during the PREADY cycle of a write.
    psel[0] = 1; penable[0] = 0; paddr[0] = 32'h8; pwrite[0] = 1; pwdata[0] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable[0] = 1;
    chk("rst_mid_rdy", 32'(pready[0]), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel[0] = 0; penable[0] = 0;
    outputs_zero(0, "rst_mid");
    clear_model();
    xfer(0, 1'b0, 32'h8, 32'h0);
    chk("rst_dropped", last_rd, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 30; t++) begin
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = 32'($urandom_range(0, 15) * 4);
        else if (sel == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else               a = 32'(64 + $urandom_range(0, 255) * 4);
        xfer(k, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
